simon_ctrl_fsm: RTL and testbench
=================================

// Module: simon_ctrl_fsm
// PURPOSE
//   Parametrised control FSM for the Simon cipher datapath. It sequences key-schedule generation and then
//   ROUNDS encrypt or decrypt rounds, driving the round index and round enable.
//   It caches the expanded key, so repeat operations under the same key skip generation.
//   The result is held behind an out_valid/out_ready handshake. Sits between the host interface, the key
//   expander and the round datapath.
// PARAMETERS
//   ROUNDS   32  rounds per block (32 = Simon32/64); legal range 2..2**ROUND_W
//   ROUND_W  5   width of round counter/index
// PORTS
//   clk            in   1        system clock, all logic on posedge
//   res            in   1        synchronous reset, active-high
//   start          in   1        request one block operation; sampled only in IDLE
//   ctrl           in   1        mode at start: 0 = encrypt, 1 = decrypt
//   key_load       in   1        new key presented; invalidates cached schedule
//   key_done       in   1        key expander finished full schedule
//   out_ready      in   1        consumer accepts result
//   state          out  5        one-hot state: IDLE=00001 KEYGEN=00010 ENC=00100 DEC=01000 DONE=10000
//   key_gen_start  out  1        1-cycle pulse: key expander (re)starts
//   key_gen_en     out  1        high throughout KEYGEN
//   round_en       out  1        datapath performs one round this cycle
//   round          out  ROUND_W  key index for this round
//   busy           out  1        state != IDLE
//   keys_valid     out  1        cached schedule matches current key
//   out_valid      out  1        result available (high in DONE)
// BEHAVIOUR
//   Reset: state=IDLE, all pulses/enables 0, round=0, keys_valid=0, mode latch=0, counter=0.
//     res overrides every event, including mid-operation.
//   All outputs are registered or decoded from registered state. No combinational input->output path.
//   IDLE
//     start=1: latch ctrl as mode and clear counter.
//     keys_valid=0 -> KEYGEN, asserting key_gen_start in the first KEYGEN cycle.
//     keys_valid=1 -> ENC (mode 0) or DEC (mode 1).
//   KEYGEN: key_gen_en=1.
//     key_done=1 and key_load=0: keys_valid<=1, go to the latched mode state.
//     key_load=1 (with or without key_done): stay in KEYGEN, keys_valid stays 0, re-pulse key_gen_start
//       on the next cycle.
//   ENC/DEC: round_en=1 every cycle; counter increments 0..ROUNDS-1.
//     ENC: round = counter. DEC: round = ROUNDS-1-counter.
//     In the cycle with counter==ROUNDS-1 -> DONE; counter returns to 0.
//   DONE: out_valid=1 and held until out_ready=1, then -> IDLE on the next edge.
//   start in any state but IDLE is ignored and is not queued.
//   key_load outside KEYGEN clears keys_valid on the next edge. An in-flight ENC/DEC still completes.
//     The next start regenerates the schedule.
//   Latency
//     keys_valid=1: start edge -> first round_en 1 cycle, out_valid ROUNDS+1 cycles after start.
//     keys_valid=0: add KEYGEN cycles (1 + cycles until key_done).
//     Back-to-back: start may be asserted in the IDLE cycle right after the DONE handshake.
//   Illegal state encodings -> IDLE, all enables 0.
// TESTING
//   Reset: res=1 for 2 cycles -> state=00001, busy=0, round=0, keys_valid=0, out_valid=0.
//   Cold encrypt: start,ctrl=0 with no key cached -> key_gen_start pulse and KEYGEN.
//     key_done 8 cycles later -> ENC, round 0..31 over 32 cycles -> DONE.
//     out_ready=1 -> IDLE.
//   Warm decrypt: start,ctrl=1, keys_valid=1 -> DEC next cycle, round 31..0.
//     out_valid high exactly 33 cycles after start.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held, state stays 10000.
//     start pulses in this window are ignored.
//   Key change: key_load during ENC -> op completes, keys_valid=0. Next start enters KEYGEN.
//     key_load and key_done together in KEYGEN -> remain KEYGEN with a second key_gen_start pulse.
//   Reset mid-op: res=1 at DEC round 10 -> next cycle IDLE, round_en=0, keys_valid=0, out_valid=0.
//   Param sweep: ROUNDS=4, ROUND_W=2 -> ENC emits round 0,1,2,3, then DONE.

Source files
------------

// File: rtl/simon_ctrl_fsm.sv
// Control sequencer for the Simon cipher: key-schedule generation, then
// ROUNDS encrypt/decrypt rounds, with a cached schedule and an output handshake.
module simon_ctrl_fsm #(
    parameter int ROUNDS  = 32,
    parameter int ROUND_W = 5
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic               ctrl,
    input  logic               key_load,
    input  logic               key_done,
    input  logic               out_ready,
    output logic [4:0]         state,
    output logic               key_gen_start,
    output logic               key_gen_en,
    output logic               round_en,
    output logic [ROUND_W-1:0] round,
    output logic               busy,
    output logic               keys_valid,
    output logic               out_valid
);

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_KEYGEN = 5'b00010;
    localparam logic [4:0] S_ENC    = 5'b00100;
    localparam logic [4:0] S_DEC    = 5'b01000;
    localparam logic [4:0] S_DONE   = 5'b10000;

    localparam logic [ROUND_W-1:0] LAST = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUND_W-1:0] ONE  = ROUND_W'(1);

    logic [4:0]         state_q;
    logic [4:0]         state_d;
    logic               mode_q;
    logic [ROUND_W-1:0] cnt_q;
    logic               kgs_q;
    logic               kv_q;
    logic               in_round;
    logic               take;

    assign in_round = (state_q == S_ENC) || (state_q == S_DEC);
    assign take     = (state_q == S_IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mode is latched on the same edge, so IDLE uses ctrl
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!start)
                    state_d = S_IDLE;
                else if (!kv_q)
                    state_d = S_KEYGEN;
                else
                    state_d = ctrl ? S_DEC : S_ENC;
            end
            S_KEYGEN: begin
                if (key_done && !key_load)
                    state_d = mode_q ? S_DEC : S_ENC;
                else
                    state_d = S_KEYGEN;
            end
            S_ENC, S_DEC: begin
                state_d = (cnt_q == LAST) ? S_DONE : state_q;
            end
            S_DONE: begin
                state_d = out_ready ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mode latch, round counter, schedule-valid flag and key_gen_start pulse
    always_ff @(posedge clk) begin
        if (res) begin
            mode_q <= 1'b0;
            cnt_q  <= '0;
            kgs_q  <= 1'b0;
            kv_q   <= 1'b0;
        end else begin
            kgs_q <= (take && !kv_q)
                  || ((state_q == S_KEYGEN) && key_load);
            if (take)
                mode_q <= ctrl;
            if (take)
                cnt_q <= '0;
            else if (in_round)
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
            if (state_q == S_KEYGEN) begin
                if (key_load)
                    kv_q <= 1'b0;
                else if (key_done)
                    kv_q <= 1'b1;
            end else if (key_load) begin
                kv_q <= 1'b0;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        key_gen_en = 1'b0;
        round_en   = 1'b0;
        round      = '0;
        out_valid  = 1'b0;
        case (state_q)
            S_KEYGEN: key_gen_en = 1'b1;
            S_ENC: begin
                round_en = 1'b1;
                round    = cnt_q;
            end
            S_DEC: begin
                round_en = 1'b1;
                round    = LAST - cnt_q;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign state         = state_q;
    assign busy          = (state_q != S_IDLE);
    assign key_gen_start = kgs_q;
    assign keys_valid    = kv_q;

endmodule

// File: tb/tb_simon_ctrl_fsm.sv
// Directed bench for simon_ctrl_fsm: vector table for the opening sequence,
// hand-written runs for long operations, key change, backpressure and reset.
module tb_simon_ctrl_fsm;

    localparam logic [4:0] IDLE   = 5'b00001;
    localparam logic [4:0] KEYGEN = 5'b00010;
    localparam logic [4:0] ENC    = 5'b00100;
    localparam logic [4:0] DEC    = 5'b01000;
    localparam logic [4:0] DONE   = 5'b10000;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic res, start, ctrl, key_load, key_done, out_ready;
    logic [4:0] state;
    logic kgs, kge, ren, busy, kv, ov;
    logic [4:0] round;

    logic s_start, s_ctrl, s_key_load, s_key_done, s_out_ready;
    logic [4:0] s_state;
    logic s_kgs, s_kge, s_ren, s_busy, s_kv, s_ov;
    logic [1:0] s_round;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    simon_ctrl_fsm dut (
        .clk(clk), .res(res), .start(start), .ctrl(ctrl),
        .key_load(key_load), .key_done(key_done), .out_ready(out_ready),
        .state(state), .key_gen_start(kgs), .key_gen_en(kge),
        .round_en(ren), .round(round), .busy(busy),
        .keys_valid(kv), .out_valid(ov)
    );

    simon_ctrl_fsm #(.ROUNDS(4), .ROUND_W(2)) dut4 (
        .clk(clk), .res(res), .start(s_start), .ctrl(s_ctrl),
        .key_load(s_key_load), .key_done(s_key_done),
        .out_ready(s_out_ready),
        .state(s_state), .key_gen_start(s_kgs), .key_gen_en(s_kge),
        .round_en(s_ren), .round(s_round), .busy(s_busy),
        .keys_valid(s_kv), .out_valid(s_ov)
    );

    typedef struct {
        logic r, s, c, kl, kd, orr;
        logic [4:0] st;
        logic kgs, kge, ren;
        logic [4:0] rnd;
        logic kv, ov;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(
        logic r, logic s, logic c, logic kl, logic kd, logic orr,
        logic [4:0] st, logic g, logic e, logic re,
        logic [4:0] rnd, logic k, logic o);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.kl = kl; v.kd = kd; v.orr = orr;
        v.st = st; v.kgs = g; v.kge = e; v.ren = re;
        v.rnd = rnd; v.kv = k; v.ov = o;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic c,
                        input logic kl, input logic kd, input logic orr);
        res = r; start = s; ctrl = c;
        key_load = kl; key_done = kd; out_ready = orr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input logic [4:0] st,
                              input logic g, input logic e, input logic re,
                              input logic [4:0] rnd, input logic k,
                              input logic o);
        chk({nm, ".state"}, int'(state), int'(st));
        chk({nm, ".kgs"}, int'(kgs), int'(g));
        chk({nm, ".kge"}, int'(kge), int'(e));
        chk({nm, ".ren"}, int'(ren), int'(re));
        chk({nm, ".round"}, int'(round), int'(rnd));
        chk({nm, ".busy"}, int'(busy), int'(st != IDLE));
        chk({nm, ".kv"}, int'(kv), int'(k));
        chk({nm, ".ov"}, int'(ov), int'(o));
    endtask

    task automatic tick4(input logic s, input logic kd);
        s_start = s; s_key_done = kd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; start = 1'b0; ctrl = 1'b0;
        key_load = 1'b0; key_done = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_ctrl = 1'b0; s_key_load = 1'b0;
        s_key_done = 1'b0; s_out_ready = 1'b0;

        // r  s  c  kl kd or  state   kgs kge ren rnd kv ov
        tbl[0]  = mk(H, L, L, L, L, L, IDLE,   L, L, L, 5'd0, L, L);
        tbl[1]  = mk(H, L, L, L, L, L, IDLE,   L, L, L, 5'd0, L, L);
        tbl[2]  = mk(L, L, L, L, L, L, IDLE,   L, L, L, 5'd0, L, L);
        tbl[3]  = mk(L, H, L, L, L, L, KEYGEN, H, H, L, 5'd0, L, L);
        tbl[4]  = mk(L, L, L, L, L, L, KEYGEN, L, H, L, 5'd0, L, L);
        tbl[5]  = mk(L, L, L, H, H, L, KEYGEN, H, H, L, 5'd0, L, L);
        tbl[6]  = mk(L, L, L, L, L, L, KEYGEN, L, H, L, 5'd0, L, L);
        tbl[7]  = mk(L, H, H, L, L, L, KEYGEN, L, H, L, 5'd0, L, L);
        tbl[8]  = mk(L, L, L, L, H, L, ENC,    L, L, H, 5'd0, H, L);
        tbl[9]  = mk(L, L, L, L, L, L, ENC,    L, L, H, 5'd1, H, L);
        tbl[10] = mk(L, L, L, L, L, L, ENC,    L, L, H, 5'd2, H, L);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].kl, tbl[i].kd,
                 tbl[i].orr);
            expect_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].kgs,
                       tbl[i].kge, tbl[i].ren, tbl[i].rnd, tbl[i].kv,
                       tbl[i].ov);
        end

        // key_load mid-encrypt: op completes, schedule invalidated
        for (int r = 3; r < 32; r++) begin
            step(L, L, L, (r == 10), L, L);
            expect_all($sformatf("enc_r%0d", r), ENC, L, L, H, 5'(r),
                       (r < 10), L);
        end
        step(L, L, L, L, L, L);
        expect_all("enc_done", DONE, L, L, L, 5'd0, L, H);

        // backpressure with ignored start pulses
        for (int i = 0; i < 5; i++) begin
            step(L, (i % 2 == 0), L, L, L, L);
            expect_all($sformatf("bp%0d", i), DONE, L, L, L, 5'd0, L, H);
        end
        step(L, L, L, L, L, H);
        expect_all("bp_release", IDLE, L, L, L, 5'd0, L, L);

        // cold start after key change regenerates
        step(L, H, L, L, L, L);
        expect_all("cold_kg", KEYGEN, H, H, L, 5'd0, L, L);
        for (int i = 0; i < 7; i++) begin
            step(L, L, L, L, L, L);
            expect_all($sformatf("cold_wait%0d", i), KEYGEN, L, H, L,
                       5'd0, L, L);
        end
        step(L, L, L, L, H, L);
        expect_all("cold_r0", ENC, L, L, H, 5'd0, H, L);
        for (int r = 1; r < 32; r++) begin
            step(L, L, L, L, L, L);
            chk($sformatf("cold_r%0d", r), int'(round), r);
        end
        step(L, L, L, L, L, L);
        expect_all("cold_done", DONE, L, L, L, 5'd0, H, H);
        step(L, L, L, L, L, H);
        expect_all("cold_idle", IDLE, L, L, L, 5'd0, H, L);

        // warm decrypt: rounds 31..0, out_valid on the 33rd edge
        step(L, H, H, L, L, L);
        expect_all("warm_r31", DEC, L, L, H, 5'd31, H, L);
        for (int k = 2; k <= 32; k++) begin
            step(L, L, L, L, L, L);
            chk($sformatf("warm_k%0d.round", k), int'(round), 32 - k);
            chk($sformatf("warm_k%0d.ov", k), int'(ov), 0);
        end
        step(L, L, L, L, L, L);
        expect_all("warm_done", DONE, L, L, L, 5'd0, H, H);

        // back-to-back start, then reset at DEC round 10
        step(L, L, L, L, L, H);
        expect_all("b2b_idle", IDLE, L, L, L, 5'd0, H, L);
        step(L, H, H, L, L, H);
        expect_all("b2b_r31", DEC, L, L, H, 5'd31, H, L);
        for (int k = 2; k <= 22; k++)
            step(L, L, L, L, L, L);
        expect_all("pre_rst_r10", DEC, L, L, H, 5'd10, H, L);
        step(H, L, L, L, L, L);
        expect_all("mid_rst", IDLE, L, L, L, 5'd0, L, L);
        step(L, L, L, L, L, L);

        // ROUNDS=4 instance
        tick4(H, L);
        chk("p4_kg.state", int'(s_state), int'(KEYGEN));
        chk("p4_kg.kgs", int'(s_kgs), 1);
        tick4(L, H);
        chk("p4_r0.state", int'(s_state), int'(ENC));
        chk("p4_r0.round", int'(s_round), 0);
        for (int r = 1; r < 4; r++) begin
            tick4(L, L);
            chk($sformatf("p4_r%0d.round", r), int'(s_round), r);
            chk($sformatf("p4_r%0d.ren", r), int'(s_ren), 1);
        end
        tick4(L, L);
        chk("p4_done.state", int'(s_state), int'(DONE));
        chk("p4_done.ov", int'(s_ov), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
